rx_engine: RTL and testbench

//  Receive engine of the full UART, the far-end counterpart of the transmit engine.
//  - Deserialises the asynchronous RX line into 7- or 8-bit characters.
//  - Uses the same configuration inputs as the transmitter: BAUD_K, EIGHT, PEN and OHEL.
//  - Flags parity, framing and overflow errors.
//  - Raises RX_RDY to interrupt the TramelBlaze. The processor acknowledges with clr_rdy.

---
 rtl/rx_engine_pkg.sv | 24 ++
 rtl/rx_bit_timer.sv | 45 ++++
 rtl/rx_engine.sv | 172 +++++++++++++++++
 tb/tb_rx_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_engine_pkg.sv
// -----------------------------------------------------------------------------
// rx_engine_pkg
// Shared definitions for the UART receive engine: FSM state encoding, the
// longest frame the shift register holds, the default width of the
// clocks-per-bit input (shared with the transmit engine) and a helper that
// computes the frame length after the start bit.
// -----------------------------------------------------------------------------
package rx_engine_pkg;

  localparam int KW_DEFAULT = 19;  // width of BAUD_K
  localparam int FRAME_MAX  = 10;  // 8 data + parity + stop

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } rx_state_t;

  // Bits sampled after the start bit: data bits + optional parity + stop.
  function automatic logic [3:0] frame_len(input logic eight, input logic pen);
    return 4'd8 + {3'd0, eight} + {3'd0, pen};
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// -----------------------------------------------------------------------------
// rx_bit_timer
// Bit-time counter for the receive engine. While run=1 it counts clocks and
// pulses btu for one cycle every BAUD_K clocks (every BAUD_K>>1 clocks when
// half=1), wrapping to 0 on that pulse. run=0 holds the count at 0.
//
// Ports
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   run     in   enable counting; 0 holds the count at 0
//   half    in   1 = half-bit terminal count (start-bit centring)
//   BAUD_K  in   clocks per bit time (>= 2)
//   btu     out  one-cycle bit-time-up pulse
// -----------------------------------------------------------------------------
module rx_bit_timer
  import rx_engine_pkg::*;
#(
  parameter int KW = KW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          half,
  input  logic [KW-1:0] BAUD_K,
  output logic          btu
);

  logic [KW-1:0] cnt_q;
  logic [KW-1:0] term;

  // The pulse fires on the cycle the count would reach the terminal value,
  // so one full period is exactly 'term' clocks.
  always_comb begin
    term = half ? (BAUD_K >> 1) : BAUD_K;
    btu  = run && (cnt_q == term - KW'(1));
  end

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || !run || btu) cnt_q <= '0;
    else                      cnt_q <= cnt_q + KW'(1);
  end

endmodule

// File: rtl/rx_engine.sv
// -----------------------------------------------------------------------------
// rx_engine
// UART receive engine. Synchronises the RX line, finds the start bit, samples
// 7 or 8 data bits (plus optional parity and the stop bit) mid-bit, and
// presents the character with sticky ready / parity / framing / overflow
// flags until the processor acknowledges with clr_rdy.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   RX       in   serial line, idles high
//   BAUD_K   in   clocks per bit time (>= 2)
//   EIGHT    in   1 = 8 data bits, 0 = 7 data bits
//   PEN      in   1 = parity bit present
//   OHEL     in   1 = odd parity, 0 = even parity
//   clr_rdy  in   one-cycle acknowledge; clears RX_RDY and all error flags
//   RX_DATA  out  received character (bit 7 = 0 in 7-bit mode)
//   RX_RDY   out  character available, sticky
//   PERR     out  parity error, sticky
//   FERR     out  framing error (stop bit 0), sticky
//   OVF      out  frame completed while RX_RDY was already set, sticky
// -----------------------------------------------------------------------------
module rx_engine
  import rx_engine_pkg::*;
#(
  parameter int KW    = KW_DEFAULT,
  parameter int NSYNC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RX,
  input  logic [KW-1:0] BAUD_K,
  input  logic          EIGHT,
  input  logic          PEN,
  input  logic          OHEL,
  input  logic          clr_rdy,
  output logic [7:0]    RX_DATA,
  output logic          RX_RDY,
  output logic          PERR,
  output logic          FERR,
  output logic          OVF
);

  // ---------------------------------------------------------------- sync
  logic [NSYNC-1:0] sync_q;
  logic             rxs;

  // Flops reset to 1 so the idle-high line never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= NSYNC'({sync_q, RX});
  end

  assign rxs = sync_q[NSYNC-1];

  // ---------------------------------------------------------------- timer
  logic run, half, btu;

  rx_bit_timer #(.KW(KW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .half   (half),
    .BAUD_K (BAUD_K),
    .btu    (btu)
  );

  // ---------------------------------------------------------------- FSM
  rx_state_t              state_q, state_d;
  logic                   sample, done;
  logic [3:0]             bitcnt_q, n_bits;
  logic [FRAME_MAX-1:0]   sr_q, sr_next;

  assign n_bits  = frame_len(EIGHT, PEN);
  assign sr_next = FRAME_MAX'({rxs, sr_q} >> 1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    half    = 1'b0;
    sample  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs) state_d = START;
      end
      START: begin
        run  = 1'b1;
        half = 1'b1;
        // Mid start bit: still low means a real start, otherwise a glitch.
        if (btu) state_d = rxs ? IDLE : DATA;
      end
      DATA: begin
        run = 1'b1;
        if (btu) begin
          sample = 1'b1;
          // '>=' keeps the FSM returning to IDLE even if the frame length
          // is changed mid-frame.
          if (bitcnt_q + 4'd1 >= n_bits) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE) bitcnt_q <= '0;
    else if (sample)              bitcnt_q <= bitcnt_q + 4'd1;
  end

  // NOTE: the shift register is reset like any control flop; a reset in
  // mid-frame discards the partial character.
  always_ff @(posedge clk) begin
    if (reset)       sr_q <= '1;
    else if (sample) sr_q <= sr_next;
  end

  // ---------------------------------------------------------------- remap
  // Evaluated from sr_next so the final (stop) sample is included on the
  // done cycle itself.
  logic [8:0] aligned;
  logic [7:0] data;
  logic       par_bit, perr_new, ferr_new;

  always_comb begin
    aligned  = 9'(sr_next >> (4'(FRAME_MAX) - n_bits));
    data     = EIGHT ? aligned[7:0] : {1'b0, aligned[6:0]};
    par_bit  = EIGHT ? aligned[8] : aligned[7];
    perr_new = PEN & (par_bit != (^data ^ OHEL));
    ferr_new = ~sr_next[FRAME_MAX-1];
  end

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      RX_DATA <= '0;
      RX_RDY  <= 1'b0;
      PERR    <= 1'b0;
      FERR    <= 1'b0;
      OVF     <= 1'b0;
    end else if (done) begin
      RX_DATA <= data;
      RX_RDY  <= 1'b1;
      if (clr_rdy) begin
        // Acknowledge lands with a new frame: report this frame only.
        PERR <= perr_new;
        FERR <= ferr_new;
        OVF  <= 1'b0;
      end else begin
        PERR <= PERR | perr_new;
        FERR <= FERR | ferr_new;
        OVF  <= OVF | RX_RDY;
      end
    end else if (clr_rdy) begin
      RX_RDY <= 1'b0;
      PERR   <= 1'b0;
      FERR   <= 1'b0;
      OVF    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_engine.sv
// -----------------------------------------------------------------------------
// tb_rx_engine
// Self-checking bench for rx_engine at BAUD_K = 16 with the line driven at
// 16 clocks per bit. A table of frames with hand-derived results, a few
// hand-written corner sequences and randomised frames checked against a
// frame-level reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_engine;
  import rx_engine_pkg::*;

  localparam int KW  = 19;
  localparam int K   = 16;
  localparam int GAP = 24;   // idle clocks after each frame

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          RX      = 1'b1;
  logic [KW-1:0] BAUD_K  = KW'(K);
  logic          EIGHT   = 1'b1;
  logic          PEN     = 1'b0;
  logic          OHEL    = 1'b0;
  logic          clr_rdy = 1'b0;
  logic [7:0]    RX_DATA;
  logic          RX_RDY, PERR, FERR, OVF;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model of the visible outputs.
  logic [7:0] m_data;
  bit         m_rdy, m_perr, m_ferr, m_ovf;

  rx_engine #(.KW(KW), .NSYNC(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .RX      (RX),
    .BAUD_K  (BAUD_K),
    .EIGHT   (EIGHT),
    .PEN     (PEN),
    .OHEL    (OHEL),
    .clr_rdy (clr_rdy),
    .RX_DATA (RX_DATA),
    .RX_RDY  (RX_RDY),
    .PERR    (PERR),
    .FERR    (FERR),
    .OVF     (OVF)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d;
    bit         e, p, o, par, stop, clr;
    logic [7:0] x_data;
    bit         x_rdy, x_perr, x_ferr, x_ovf;
  } vec_t;

  vec_t tbl[11];

  // ------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input bit r,
                            input bit p, input bit f, input bit o);
    check({tag, "_data"}, 16'(RX_DATA), 16'(d));
    check({tag, "_rdy"},  16'(RX_RDY),  16'(r));
    check({tag, "_perr"}, 16'(PERR),    16'(p));
    check({tag, "_ferr"}, 16'(FERR),    16'(f));
    check({tag, "_ovf"},  16'(OVF),     16'(o));
  endtask

  task automatic check_model(input string tag);
    check_outs(tag, m_data, m_rdy, m_perr, m_ferr, m_ovf);
  endtask

  task automatic model_reset();
    m_data = '0; m_rdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
  endtask

  // Apply the frame rules to the model: data masked to the character width,
  // parity checked by counting ones, sticky flags accumulated.
  task automatic model_frame(input logic [7:0] d, input bit par, input bit stop,
                             input bit clr_same);
    logic [7:0] dm;
    bit         want_par, perr_n;
    dm       = EIGHT ? d : (d & 8'h7F);
    want_par = (($countones(dm) % 2) == 1) ^ OHEL;
    perr_n   = PEN && (par != want_par);
    if (clr_same) begin
      m_perr = perr_n;
      m_ferr = !stop;
      m_ovf  = 0;
    end else begin
      m_ovf  = m_ovf | m_rdy;
      m_perr = m_perr | perr_n;
      m_ferr = m_ferr | !stop;
    end
    m_rdy  = 1;
    m_data = dm;
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (K) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit par, input bit stop);
    drive_bit(1'b0);
    for (int i = 0; i < (EIGHT ? 8 : 7); i++) drive_bit(d[i]);
    if (PEN) drive_bit(par);
    drive_bit(stop);
    RX = 1'b1;
  endtask

  task automatic pulse_clr_at_done();
    int t = 0;
    while (dut.done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 16'(t < 400), 16'd1);
    if (t < 400) begin
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input bit stop,
                            input bit clr_at_done);
    if (clr_at_done) begin
      fork
        drive_frame(d, par, stop);
        pulse_clr_at_done();
      join
    end else begin
      drive_frame(d, par, stop);
    end
    model_frame(d, par, stop, clr_at_done);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic do_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    @(negedge clk);
    m_rdy = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic set_cfg(input bit e, input bit p, input bit o);
    EIGHT = e; PEN = p; OHEL = o;
  endtask

  // ------------------------------------------------------------- test
  initial begin
    //          d      e  p  o  par stop clr  x_data rdy perr ferr ovf
    tbl[0]  = '{8'hA5, 1, 0, 0, 0,  1,   1,   8'hA5, 1,  0,   0,   0};
    tbl[1]  = '{8'h3C, 1, 1, 0, 1,  1,   1,   8'h3C, 1,  1,   0,   0};
    tbl[2]  = '{8'h41, 0, 1, 1, 1,  1,   1,   8'h41, 1,  0,   0,   0};
    tbl[3]  = '{8'hFF, 1, 0, 0, 0,  0,   1,   8'hFF, 1,  0,   1,   0};
    tbl[4]  = '{8'h12, 1, 0, 0, 0,  1,   0,   8'h12, 1,  0,   0,   0};
    tbl[5]  = '{8'h34, 1, 0, 0, 0,  1,   1,   8'h34, 1,  0,   0,   1};
    tbl[6]  = '{8'hC1, 0, 0, 0, 0,  1,   1,   8'h41, 1,  0,   0,   0};
    tbl[7]  = '{8'h7F, 0, 1, 0, 0,  1,   1,   8'h7F, 1,  1,   0,   0};
    tbl[8]  = '{8'h00, 1, 1, 1, 1,  1,   1,   8'h00, 1,  0,   0,   0};
    tbl[9]  = '{8'h96, 1, 1, 0, 1,  0,   0,   8'h96, 1,  1,   1,   0};
    tbl[10] = '{8'h6B, 1, 1, 0, 1,  1,   1,   8'h6B, 1,  1,   1,   1};

    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check_outs("reset", 8'h00, 0, 0, 0, 0);
    check("reset_state_idle", 16'(dut.state_q == IDLE), 16'd1);
    check("reset_shift_ones", 16'(dut.sr_q), 16'h03FF);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) begin
      set_cfg(tbl[i].e, tbl[i].p, tbl[i].o);
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 1'b0);
      check_outs($sformatf("vec%0d", i), tbl[i].x_data, tbl[i].x_rdy,
                 tbl[i].x_perr, tbl[i].x_ferr, tbl[i].x_ovf);
      if (tbl[i].clr) begin
        do_clr();
        check_outs($sformatf("vec%0d_clr", i), tbl[i].x_data, 0, 0, 0, 0);
      end
    end

    // Start-bit glitch shorter than half a bit.
    set_cfg(1, 0, 0);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (GAP) @(negedge clk);
    check("glitch_rdy", 16'(RX_RDY), 16'd0);
    check("glitch_state_idle", 16'(dut.state_q == IDLE), 16'd1);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    check_model("glitch_next");

    // Reset in the middle of data bit 4 (RX_RDY is set from 0x55).
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'hC3 >> i) & 8'h01));
    RX = 1'b1;
    repeat (K / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_outs("midreset", 8'h00, 0, 0, 0, 0);
    check("midreset_state_idle", 16'(dut.state_q == IDLE), 16'd1);
    repeat (GAP) @(negedge clk);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    check_model("after_reset");

    // Parity error while RX_RDY still set, then clr_rdy on the done cycle.
    set_cfg(1, 1, 0);
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    check_model("perr_ovf");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    check_model("clr_at_done");

    // Randomised frames against the model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit e, p, o, par, stop;
      e    = 1'($urandom_range(0, 1));
      p    = 1'($urandom_range(0, 1));
      o    = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      set_cfg(e, p, o);
      par  = ((($countones(e ? d : (d & 8'h7F)) % 2) == 1) ^ o) ^ ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        do_clr();
        check_model($sformatf("rnd%0d_clr", i));
      end
      send_frame(d, par, stop, 1'b0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
